iter_div: RTL and testbench
===========================

Name: iter_div

Overview:
- Multi-cycle RV32M divide unit for DIV, DIVU, REM and REMU.
- Uses radix-2 restoring division: one subtract-and-shift per cycle, 32 iterations per operation.
- Sits beside the ALU in the execute stage. The control unit stalls the PC/pipeline while BUSY is high and writes RESULT to the register file when VALID pulses.

Parameters:
- XLEN, 32, operand and result width (only 32 is supported).
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  request; accepted only when READY=1.
- OP  in  2  operation select (funct3[1:0]): 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- A  in  32  dividend (rs1).
- B  in  32  divisor (rs2).
- FLUSH  in  1  synchronous abort.
- READY  out  1  unit is idle and can accept START.
- BUSY  out  1  operation in progress.
- VALID  out  1  one-cycle pulse; RESULT is valid.
- RESULT  out  32  quotient or remainder, held until the next accepted START.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State goes to IDLE.
  - READY=1, BUSY=0, VALID=0, RESULT=0.
  - The iteration counter and all datapath registers clear.
- States and transitions:
  - IDLE: on START, latch OP, A, B.
    - If a special case applies, go to DONE with the result already loaded.
    - Otherwise go to PREP.
  - PREP: for signed ops, load |A| and |B| and record the quotient sign (A[31]^B[31]) and remainder sign (A[31]). For unsigned ops, load A and B unchanged. Clear the counter. Go to ITER.
  - ITER: 32 cycles.
    - Each cycle: partial remainder R (33 bits) = {R[31:0], Q[31]}; Q shifts left by 1.
    - D = R - {0,divisor}, computed 33 bits wide.
    - If D is non-negative (D[32]=0): R=D and Q[0]=1. Otherwise R is kept and Q[0]=0.
    - The counter increments; when the counter reaches 31 (CNT_W all ones), go to FIX.
  - FIX: select Q (DIV/DIVU) or R[31:0] (REM/REMU). For signed ops, negate per the recorded sign. Register the result into RESULT. Go to DONE.
  - DONE: VALID=1 for exactly this cycle. Go to IDLE unconditionally.
- Outputs by state:
  - READY=1 only in IDLE; START in any other state is ignored.
  - BUSY=1 in PREP, ITER and FIX.
- Latency, with START sampled at edge 0:
  - Normal operation: VALID is high in the cycle after edge 34, i.e. 35 cycles after START is asserted. Back-to-back throughput is one operation per 36 cycles.
  - Special case: VALID is high in the cycle after edge 0 (latency 1).
- Special cases, resolved in IDLE per the RISC-V spec:
  - B=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - DIV/REM with A=0x80000000 and B=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- Width and sign rules:
  - Absolute value of 0x80000000 is taken as the unsigned value 0x80000000 (no overflow in the 32-bit magnitude).
  - Remainder sign always follows the dividend; quotient truncates toward zero.
- FLUSH:
  - In any non-IDLE state: next edge goes to IDLE, with no VALID pulse and RESULT unchanged.
  - FLUSH has priority over START in the same cycle; no request is accepted that cycle.
  - FLUSH in DONE suppresses nothing: VALID is still high during that cycle.
- Reset mid-operation: asynchronous return to IDLE, with outputs at their reset values immediately.

Decomposition:
- Shared package holds:
  - OP encodings: OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11.
  - State encoding: IDLE, PREP, ITER, FIX, DONE.
  - Constants XLEN=32, INT_MIN=32'h80000000, ALL_ONES=32'hFFFFFFFF.
- One sub-module, cla_sub33: 33-bit subtractor built from chained 4-bit carry-lookahead slices. It computes X + ~Y + 1 and outputs the difference and its sign bit.
  - Used once in ITER.
  - The FIX negation reuses the same lookahead slice structure with X=0.

Test Plan:
- DIVU A=100, B=7: VALID 35 cycles after START, RESULT=14. The same operands with REMU give RESULT=2.
- DIV A=0xFFFFFFF9 (-7), B=2: RESULT=0xFFFFFFFD (-3). REM with the same operands gives RESULT=0xFFFFFFFF (-1).
- B=0 with A=5:
  - DIVU gives RESULT=0xFFFFFFFF.
  - REM gives RESULT=5.
  - VALID is high in the cycle after the START edge, and BUSY never rises.
- DIV A=0x80000000, B=0xFFFFFFFF: RESULT=0x80000000 at latency 1. REM with the same operands gives 0.
- START pulsed at cycle 10 of an active operation: ignored, with READY=0 and the first result unchanged. FLUSH at ITER count 12: IDLE next cycle, no VALID, RESULT holds its previous value.
- RST_N low during ITER, asynchronous to CLK: READY=1, BUSY=0, VALID=0, RESULT=0 immediately. After release, DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF.

Source files
------------

// File: rtl/iter_div_pkg.sv
// Shared constants, op encodings and FSM states for the iterative divider.
package iter_div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/iter_div_cla_sub33.sv
// 33-bit subtractor x - y from eight 4-bit lookahead slices plus a sign bit.
module cla_sub33 (
    input  logic [32:0] x,
    input  logic [32:0] y,
    output logic [31:0] diff,
    output logic        neg
);
    logic [32:0] yn;
    logic [8:0]  c;

    assign yn   = ~y;
    assign c[0] = 1'b1;

    for (genvar i = 0; i < 8; i++) begin : g_slice
        logic [3:0] g, p, cc;
        assign g     = x[4*i +: 4] & yn[4*i +: 4];
        assign p     = x[4*i +: 4] ^ yn[4*i +: 4];
        assign cc[0] = c[i];
        assign cc[1] = g[0] | (p[0] & c[i]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[i]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & c[i]);
        assign c[i+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0])
                      | (p[3] & p[2] & p[1] & p[0] & c[i]);
        assign diff[4*i +: 4] = p ^ cc;
    end

    assign neg = x[32] ^ yn[32] ^ c[8];

endmodule

// File: rtl/iter_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, 36 cycles per operation.
module iter_div
    import iter_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);
    state_t state_q, state_d;

    logic [1:0]      op_q;
    logic [XLEN-1:0] quo_q, dvs_q, rem_q, res_q;
    logic [CNT_W-1:0] cnt_q;
    logic            qneg_q, rneg_q;

    logic            accept, special, is_signed;
    logic [XLEN-1:0] special_val, sel, sub_d;
    logic [XLEN:0]   rsh, sub_x, sub_y;
    logic            sub_neg;

    assign accept    = start & ~flush;
    assign is_signed = ~op_q[0];
    assign rsh       = {rem_q, quo_q[XLEN-1]};
    assign sel       = op_q[1] ? rem_q : quo_q;
    assign result    = res_q;

    // One subtractor: trial subtract in ITER, negation (0 - sel) in FIX
    assign sub_x = (state_q == FIX) ? '0 : rsh;
    assign sub_y = {1'b0, (state_q == FIX) ? sel : dvs_q};

    cla_sub33 u_sub (
        .x    (sub_x),
        .y    (sub_y),
        .diff (sub_d),
        .neg  (sub_neg)
    );

    always_comb begin
        special     = 1'b0;
        special_val = '0;
        if (b == '0) begin
            special     = 1'b1;
            special_val = op[1] ? a : ALL_ONES;
        end else if (!op[0] && a == INT_MIN && b == ALL_ONES) begin
            special     = 1'b1;
            special_val = op[1] ? '0 : INT_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (accept) state_d = special ? DONE : PREP;
            end
            PREP: begin
                busy    = 1'b1;
                state_d = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (&cnt_q) state_d = FIX;
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q  <= op;
                    quo_q <= a;
                    dvs_q <= b;
                    rem_q <= '0;
                    if (special) res_q <= special_val;
                end
                PREP: begin
                    quo_q  <= (is_signed && quo_q[XLEN-1]) ? -quo_q : quo_q;
                    dvs_q  <= (is_signed && dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
                    qneg_q <= is_signed & (quo_q[XLEN-1] ^ dvs_q[XLEN-1]);
                    rneg_q <= is_signed & quo_q[XLEN-1];
                    rem_q  <= '0;
                    cnt_q  <= '0;
                end
                ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    quo_q <= {quo_q[XLEN-2:0], ~sub_neg};
                    rem_q <= sub_neg ? rsh[XLEN-1:0] : sub_d;
                end
                FIX: if (!flush) begin
                    res_q <= (op_q[1] ? rneg_q : qneg_q) ? sub_d : sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench: arithmetic reference model plus per-cycle compare.
module tb_iter_div;
    import iter_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b, result;
    logic        ready, busy, valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic        armed = 1'b0;
    logic        spec  = 1'b0;
    int          s_cyc = 0;
    int          exp_cyc = 0;
    logic [31:0] exp_new = '0;
    logic [31:0] held = '0;

    iter_div dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .ready  (ready),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic sg, rm;
        sg = ~o[0];
        rm = o[1];
        if (y == 0) return rm ? x : 32'hFFFF_FFFF;
        if (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return rm ? 32'h0 : 32'h8000_0000;
        if (sg) return rm ? 32'($signed(x) % $signed(y))
                          : 32'($signed(x) / $signed(y));
        return rm ? x % y : x / y;
    endfunction

    function automatic logic is_spec(input logic [1:0] o,
                                     input logic [31:0] x,
                                     input logic [31:0] y);
        return (y == 0) ||
               (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            held = '0;
        end else begin
            if (armed && cyc == exp_cyc) held = exp_new;
            chk("valid", 32'(valid), 32'(armed && cyc == exp_cyc));
            chk("ready", 32'(ready),
                32'(!(armed && cyc > s_cyc && cyc <= exp_cyc)));
            chk("busy", 32'(busy),
                32'(armed && !spec && cyc > s_cyc && cyc < exp_cyc));
            chk("result", result, held);
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        @(negedge clk);
        op      = o;
        a       = x;
        b       = y;
        start   = 1'b1;
        s_cyc   = cyc;
        exp_new = model(o, x, y);
        spec    = is_spec(o, x, y);
        exp_cyc = cyc + (spec ? 1 : 35);
        armed   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        while (cyc <= exp_cyc) @(negedge clk);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] lit);
        chk("model", model(o, x, y), lit);
        launch(o, x, y);
        wait_done();
        chk("final", result, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;

        run(OP_DIVU, 32'd100, 32'd7, 32'd14);
        run(OP_REMU, 32'd100, 32'd7, 32'd2);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run(OP_REM, 32'd5, 32'd0, 32'd5);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run(OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        run(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000);
        run(OP_REM, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE);

        // stray START mid-operation must be ignored
        launch(OP_DIVU, 32'd1000, 32'd10);
        repeat (9) @(negedge clk);
        op    = OP_DIV;
        a     = 32'd7;
        b     = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("ignored_start", result, 32'd100);

        // abort at iteration count 12
        launch(OP_DIV, 32'd12345, 32'd17);
        repeat (13) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 armed = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);
        chk("flush_hold", result, 32'd100);

        // asynchronous reset during ITER
        launch(OP_DIVU, 32'hDEAD_BEEF, 32'd3);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        armed = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
